id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32I core, directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID, and honours stall/flush from the hazard unit.
- Resolves data hazards by bypassing from MEM and WB.
- Drives the ALU operand A, operand B and 4-bit control, and flags load-use hazards back to the hazard unit.

---
 rtl/core_pkg.sv | 37 +++
 rtl/fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared ALU op codes, operand select encodings and EX control bundle
package core_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_AP4  = 4'd11;
    localparam logic [3:0] ALU_BOUT = 4'd12;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_ctrl;
        logic [1:0] src_a;
        logic       src_b;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - selects MEM, WB or registered value for one EX source operand
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_val,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a writer targeting it never supplies a value
    assign mem_hit = mem_valid && mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
    assign wb_hit  = wb_valid  && wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

    always_comb begin
        fwd_data = rs_val;
        if (mem_hit) begin
            fwd_data = mem_data;
        end else if (wb_hit) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with MEM/WB bypass and load-use detection
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [1:0]        id_src_a,
    input  logic              id_src_b,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_alu_a,
    output logic [XLEN-1:0]   ex_alu_b,
    output logic [3:0]        ex_alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              load_use_hazard
);

    ex_ctrl_t          ctrl_q;
    ex_ctrl_t          ctrl_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_val_q;
    logic [XLEN-1:0]   rs2_val_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [REG_AW-1:0] rd_addr_q;

    logic              wb_hit_rs1;
    logic              wb_hit_rs2;
    logic [XLEN-1:0]   rs1_cap;
    logic [XLEN-1:0]   rs2_cap;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    logic              clear;

    // WB retires this edge, so its value never reaches the regfile read ID just did
    assign wb_hit_rs1 = wb_valid && wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr);
    assign wb_hit_rs2 = wb_valid && wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr);
    assign rs1_cap    = wb_hit_rs1 ? wb_data : id_rs1_data;
    assign rs2_cap    = wb_hit_rs2 ? wb_data : id_rs2_data;

    always_comb begin
        ctrl_d           = EX_CTRL_BUBBLE;
        ctrl_d.valid     = 1'b1;
        ctrl_d.alu_ctrl  = id_alu_ctrl;
        ctrl_d.src_a     = id_src_a;
        ctrl_d.src_b     = id_src_b;
        ctrl_d.reg_write = id_reg_write;
        ctrl_d.mem_read  = id_mem_read;
        ctrl_d.mem_write = id_mem_write;
    end

    // An empty ID slot is loaded exactly like a flush bubble
    assign clear = rst || flush || (!stall && !id_valid);

    always_ff @(posedge clk) begin
        if (clear) begin
            ctrl_q     <= EX_CTRL_BUBBLE;
            pc_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
        end else if (!stall) begin
            ctrl_q     <= ctrl_d;
            pc_q       <= id_pc;
            rs1_val_q  <= rs1_cap;
            rs2_val_q  <= rs2_cap;
            imm_q      <= id_imm;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rd_addr_q  <= id_rd_addr;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr       (rs1_addr_q),
        .rs_val        (rs1_val_q),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_data      (mem_fwd_data),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr       (rs2_addr_q),
        .rs_val        (rs2_val_q),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_data      (mem_fwd_data),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs2)
    );

    always_comb begin
        ex_alu_a = '0;
        case (ctrl_q.src_a)
            SRC_A_RS1: ex_alu_a = fwd_rs1;
            SRC_A_PC:  ex_alu_a = pc_q;
            default:   ex_alu_a = '0;
        endcase
    end

    assign ex_alu_b      = (ctrl_q.src_b == SRC_B_IMM) ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    assign ex_valid      = ctrl_q.valid;
    assign ex_pc         = pc_q;
    assign ex_alu_ctrl   = ctrl_q.alu_ctrl;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;

    // Loaded data only exists after MEM, so a consumer right behind a load must wait
    assign load_use_hazard = ctrl_q.valid && ctrl_q.mem_read && (rd_addr_q != '0) && id_valid &&
                             ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic [1:0]  id_src_a;
    logic        id_src_b;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_fwd_data;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_a;
    logic [31:0] ex_alu_b;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        load_use_hazard;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rd_addr      (id_rd_addr),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_src_a        (id_src_a),
        .id_src_b        (id_src_b),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .mem_valid       (mem_valid),
        .mem_reg_write   (mem_reg_write),
        .mem_rd_addr     (mem_rd_addr),
        .mem_fwd_data    (mem_fwd_data),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_rd_addr      (wb_rd_addr),
        .wb_data         (wb_data),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_alu_a        (ex_alu_a),
        .ex_alu_b        (ex_alu_b),
        .ex_alu_ctrl     (ex_alu_ctrl),
        .ex_store_data   (ex_store_data),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .load_use_hazard (load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [3:0] op, input logic [1:0] sa, input logic sb,
                          input logic rw, input logic mr, input logic mw);
        id_valid = valid; id_pc = pc;
        id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2;
        id_rd_addr = rd; id_imm = imm; id_alu_ctrl = op;
        id_src_a = sa; id_src_b = sb;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic mv, input logic mw, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wv, input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
        mem_valid = mv; mem_reg_write = mw; mem_rd_addr = mrd; mem_fwd_data = md;
        wb_valid = wv; wb_reg_write = ww; wb_rd_addr = wrd; wb_data = wd;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0);

        // reset then idle
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_alu_a", ex_alu_a, 32'd0);
        chk("rst_alu_b", ex_alu_b, 32'd0);
        chk("rst_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rd", {27'd0, ex_rd_addr}, 32'd0);
        chk("rst_ctl_bits", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_luh", {31'd0, load_use_hazard}, 32'd0);

        // ADD x3,x1,x2
        set_id(1, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
        tick();
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_alu_a", ex_alu_a, 32'd5);
        chk("add_alu_b", ex_alu_b, 32'd7);
        chk("add_ctrl", {28'd0, ex_alu_ctrl}, 32'd1);
        chk("add_rd", {27'd0, ex_rd_addr}, 32'd3);
        chk("add_rw", {31'd0, ex_reg_write}, 32'd1);
        chk("add_pc", ex_pc, 32'h40);
        chk("add_store", ex_store_data, 32'd7);

        // forwarding priority on rs1=x4, rs2=x4 as well for store path
        set_id(1, 32'h44, 5'd4, 32'h99, 5'd4, 32'h99, 5'd10, 32'h0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 1, 5'd4, 32'h11, 1, 1, 5'd4, 32'h22);
        #1;
        chk("fwd_mem_a", ex_alu_a, 32'h11);
        chk("fwd_mem_store", ex_store_data, 32'h11);
        set_fwd(1, 1, 5'd0, 32'h11, 1, 1, 5'd4, 32'h22);
        #1;
        chk("fwd_wb_a", ex_alu_a, 32'h22);
        chk("fwd_wb_b", ex_alu_b, 32'h22);
        set_fwd(1, 0, 5'd4, 32'h11, 0, 1, 5'd4, 32'h22);
        #1;
        chk("fwd_none_a", ex_alu_a, 32'h99);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        set_id(1, 32'h48, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 32'h0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
        tick();
        set_fwd(1, 1, 5'd0, 32'h11, 1, 1, 5'd0, 32'h22);
        #1;
        chk("fwd_x0_a", ex_alu_a, 32'h0);
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0);

        // LW x5, 8(x1)
        set_id(1, 32'h50, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd5, 32'd8, 4'd1, 2'd0, 1'b1, 1, 1, 0);
        tick();
        chk("lw_alu_a", ex_alu_a, 32'h1000);
        chk("lw_alu_b_imm", ex_alu_b, 32'd8);
        chk("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
        set_id(1, 32'h54, 5'd7, 32'd3, 5'd5, 32'd4, 5'd8, 32'h0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
        #1;
        chk("luh_rs2", {31'd0, load_use_hazard}, 32'd1);
        id_rs2_addr = 5'd6;
        #1;
        chk("luh_nomatch", {31'd0, load_use_hazard}, 32'd0);
        id_rs1_addr = 5'd5;
        #1;
        chk("luh_rs1", {31'd0, load_use_hazard}, 32'd1);
        id_valid = 1'b0;
        #1;
        chk("luh_id_invalid", {31'd0, load_use_hazard}, 32'd0);
        set_id(1, 32'h54, 5'd7, 32'd3, 5'd5, 32'd4, 5'd8, 32'h0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        chk("bubble_mr", {31'd0, ex_mem_read}, 32'd0);
        chk("bubble_luh", {31'd0, load_use_hazard}, 32'd0);
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("relaunch_a", ex_alu_a, 32'd3);
        chk("relaunch_b", ex_alu_b, 32'd4);
        chk("relaunch_rd", {27'd0, ex_rd_addr}, 32'd8);

        // stall holds for three cycles under changing ID inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + i, 5'd9, 32'hDEAD0000 + i, 5'd9, 32'hBEEF, 5'd12, 32'h77, 4'd2 + i[3:0], 2'd1, 1'b1, 0, 1, 1);
            tick();
            chk("stall_a", ex_alu_a, 32'd3);
            chk("stall_ctrl", {28'd0, ex_alu_ctrl}, 32'd1);
            chk("stall_rd", {27'd0, ex_rd_addr}, 32'd8);
        end
        flush = 1'b1;
        tick();
        chk("stall_flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("stall_flush_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // capture-time WB bypass
        set_id(1, 32'h60, 5'd6, 32'h0, 5'd0, 32'h0, 5'd9, 32'h0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
        set_fwd(0, 0, 0, 0, 1, 1, 5'd6, 32'hABCD);
        tick();
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wb_bypass_a", ex_alu_a, 32'hABCD);

        // JAL x1: pc operand, Ap4
        set_id(1, 32'h100, 5'd2, 32'h5555, 5'd0, 32'h0, 5'd1, 32'h20, 4'd11, 2'd1, 1'b1, 1, 0, 0);
        tick();
        chk("jal_a", ex_alu_a, 32'h100);
        chk("jal_ctrl", {28'd0, ex_alu_ctrl}, 32'd11);
        chk("jal_rd", {27'd0, ex_rd_addr}, 32'd1);

        // src_a zero and the unused encoding 3
        set_id(1, 32'h104, 5'd2, 32'h5555, 5'd0, 32'h0, 5'd1, 32'h20, 4'd12, 2'd2, 1'b1, 1, 0, 0);
        tick();
        chk("srca_zero", ex_alu_a, 32'h0);
        set_id(1, 32'h108, 5'd2, 32'h5555, 5'd0, 32'h0, 5'd1, 32'h20, 4'd12, 2'd3, 1'b1, 1, 0, 0);
        tick();
        chk("srca_three", ex_alu_a, 32'h0);
        chk("store_flag", {31'd0, ex_mem_write}, 32'd0);

        // reset during stall
        stall = 1'b1; rst = 1'b1;
        tick();
        chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_pc", ex_pc, 32'h0);
        rst = 1'b0; stall = 1'b0; id_valid = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
